// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt sequencer and the jump control unit.
// Holds the sequencer state type, the RET opcode and the default vector layout.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        VECTOR,
        SERVICE
    } irq_state_t;

    localparam logic [5:0]  OP_RET         = 6'b010000;
    localparam logic [15:0] IRQ_VEC_BASE   = 16'hF000;
    localparam logic [15:0] IRQ_VEC_STRIDE = 16'h0010;

    // 16-bit wrap-around vector address for a given source index
    function automatic logic [15:0] irq_vector(input logic [15:0] base,
                                               input logic [15:0] stride,
                                               input logic [2:0]  id);
        return base + stride * {13'b0, id};
    endfunction

endpackage

// File: rtl/irq_sequencer_if.sv
// Link between the interrupt sequencer and the jump/branch control unit.
// The jump control side is the master; the sequencer is the slave.
interface irq_sequencer_if;

    logic [5:0]  op;
    logic        jump_busy;
    logic        interrupt;
    logic [2:0]  irq_id;
    logic [15:0] vec_addr;
    logic        in_service;

    modport master (
        output op,
        output jump_busy,
        input  interrupt,
        input  irq_id,
        input  vec_addr,
        input  in_service
    );

    modport slave (
        input  op,
        input  jump_busy,
        output interrupt,
        output irq_id,
        output vec_addr,
        output in_service
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: idx is the first set request bit,
// valid is high when any request is set.
module irq_prio_enc #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !valid) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Multi-source interrupt sequencer: edge-latched requests, software mask,
// fixed priority, one non-nested interrupt in service until RET.
module irq_sequencer
    import irq_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter logic [15:0] VEC_BASE   = IRQ_VEC_BASE,
    parameter logic [15:0] VEC_STRIDE = IRQ_VEC_STRIDE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    irq_sequencer_if.slave     jc,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] irq_mask
);

    irq_state_t         state;
    logic [NUM_SRC-1:0] irq_prev;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] grant_clr;
    logic [2:0]         win_idx;
    logic               win_valid;
    logic               issue_go;

    assign rise     = irq_in & ~irq_prev;
    assign eligible = pending & ~irq_mask;

    irq_prio_enc #(
        .N     (NUM_SRC),
        .IDX_W (3)
    ) u_prio (
        .req   (eligible),
        .idx   (win_idx),
        .valid (win_valid)
    );

    assign issue_go = (state == IDLE) && win_valid && !jc.jump_busy;

    always_comb begin
        grant_clr = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            grant_clr[i] = issue_go && (win_idx == 3'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            irq_prev      <= '0;
            pending       <= '0;
            irq_mask      <= '1;
            jc.interrupt  <= 1'b0;
            jc.in_service <= 1'b0;
            jc.irq_id     <= '0;
            jc.vec_addr   <= VEC_BASE;
        end else begin
            irq_prev     <= irq_in;
            // a fresh edge on the winner during grant keeps it pending
            pending      <= (pending & ~grant_clr) | rise;
            jc.interrupt <= 1'b0;
            if (mask_we) begin
                irq_mask <= mask_wdata;
            end
            case (state)
                IDLE: begin
                    if (issue_go) begin
                        state         <= ISSUE;
                        jc.irq_id     <= win_idx;
                        jc.vec_addr   <= irq_vector(VEC_BASE, VEC_STRIDE, win_idx);
                        jc.interrupt  <= 1'b1;
                        jc.in_service <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= VECTOR;
                end
                VECTOR: begin
                    state <= SERVICE;
                end
                SERVICE: begin
                    if (jc.op == OP_RET) begin
                        state         <= IDLE;
                        jc.in_service <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Multi-source interrupt controller in front of the jump/branch control unit of the 16-bit MIPS-style pipeline.
- Latches rising edges on external IRQ lines, applies a software mask, picks one source by fixed priority, and raises a single-cycle `interrupt` pulse to the jump control unit.
- Supplies a per-source vector address and holds the in-service state until the decode stage presents RET.
- No nesting: one interrupt in service at a time.

Parameters:
- NUM_SRC, 4, number of IRQ sources (1..8)
- VEC_BASE, 16'hF000, vector address of source 0
- VEC_STRIDE, 16'h0010, address distance between consecutive source vectors

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- irq_in  in  NUM_SRC  external IRQ lines; a rising edge requests service
- mask_we  in  1  write strobe for the mask register
- mask_wdata  in  NUM_SRC  new mask value (1 = source disabled)
- op  in  6  decode-stage opcode; RET = 6'b010000
- jump_busy  in  1  jump control is redirecting the PC this cycle; defers issue
- interrupt  out  1  single-cycle request to jump control
- irq_id  out  3  index of the source being serviced
- vec_addr  out  16  VEC_BASE + irq_id*VEC_STRIDE
- in_service  out  1  handler active
- pending  out  NUM_SRC  latched, not yet serviced requests
- irq_mask  out  NUM_SRC  current mask

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-service):
  - state=IDLE, pending=0, irq_mask=all ones, irq_id=0, interrupt=0, in_service=0
  - edge-detect history = 0
  - vec_addr therefore = VEC_BASE.
- Edge detect:
  - irq_prev is registered each cycle.
  - pending[i] sets on the clock where irq_in[i]=1 and irq_prev[i]=0.
  - A held level does not re-trigger.
- Mask:
  - On mask_we, irq_mask <= mask_wdata; the new value affects arbitration from the next cycle.
  - Masked edges are still latched into pending.
- Eligible = pending & ~irq_mask. Winner = lowest eligible index.
- FSM, all outputs registered/Moore:
  - IDLE: if eligible != 0 and jump_busy = 0, go to ISSUE; latch irq_id = winner; clear pending[winner]. Otherwise stay in IDLE.
  - ISSUE: interrupt = 1 for exactly this cycle; in_service = 1. Go to VECTOR.
  - VECTOR: one cycle in which jump control loads vec_addr into the PC. RET is ignored. Go to SERVICE.
  - SERVICE: wait for op == RET. On RET, go to IDLE; in_service drops the next cycle.
- in_service = 1 in ISSUE, VECTOR and SERVICE.
- irq_id and vec_addr stay stable from ISSUE until the next IDLE to ISSUE transition.
- Latency:
  - irq_in rise sampled at edge k sets pending after edge k.
  - ISSUE is entered after edge k+1, so interrupt is high in the cycle after k+1 (2-cycle latency when idle and not busy).
- Minimum gap between two interrupt pulses: RET cycle + 1 IDLE cycle.
- Simultaneous set and clear of the same pending bit (new edge on the winner during the IDLE to ISSUE transition): set wins, so the request stays pending.
- RET seen in IDLE, ISSUE or VECTOR: no effect.
- jump_busy is only sampled in IDLE.
- vec_addr arithmetic is 16-bit, wrap-around; no overflow flag.

Decomposition:
- Shared package irq_pkg holds:
  - the state enum (IDLE, ISSUE, VECTOR, SERVICE)
  - the RET opcode constant 6'b010000
  - default VEC_BASE and VEC_STRIDE
- The jump control unit should import the same RET constant.
- One sub-module: irq_prio_enc, a parameterised lowest-index-first priority encoder producing index and valid.

Test Plan:
- Reset, then idle 5 cycles -> interrupt=0, in_service=0, pending=0, irq_mask=4'b1111, vec_addr=16'hF000.
- Mask=0; pulse irq_in[2] -> pending=4'b0100 next cycle, interrupt=1 exactly one cycle later, irq_id=2, vec_addr=16'hF020, pending=0. Then op=RET in SERVICE -> in_service=0 the following cycle.
- Rise irq_in[1] and irq_in[3] together -> first service irq_id=1, vec_addr=16'hF010. After RET, second interrupt pulse with irq_id=3, vec_addr=16'hF030, exactly 2 cycles after RET.
- Mask=4'b0001; edge on irq_in[0] -> pending[0]=1, no interrupt for 10 cycles. Write mask=0 -> interrupt 2 cycles after mask_we, irq_id=0.
- pending[2] set, jump_busy=1 for 3 cycles -> no ISSUE; interrupt asserts the cycle after the first IDLE cycle with jump_busy=0.
- Reset asserted while in SERVICE with pending[3]=1 -> next cycle state=IDLE, in_service=0, pending=0, irq_mask=4'b1111; no interrupt afterwards.
